qpu_dmem_icb_slave: RTL and testbench

//  ICB responder for QPU data memory; the target side of the LSU ICB cmd/rsp channel.

---
 rtl/qpu_dmem_icb_slave.sv | 152 +++++++++++++++
 tb/tb_qpu_dmem_icb_slave.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/qpu_dmem_icb_slave.sv
// ICB target for QPU data memory: byte-masked word RAM with an in-order response FIFO.
// Optional wait states per command are enabled by defining QPU_DMEM_WAIT_EN.
module qpu_dmem_icb_slave #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DW        = 32,
   parameter int unsigned MEM_AW    = 8,
   parameter int unsigned RSP_DEPTH = 2,
   parameter int unsigned WAIT_CYC  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              icb_cmd_valid,
   output logic              icb_cmd_ready,
   input  logic [ADDR_W-1:0] icb_cmd_addr,
   input  logic              icb_cmd_read,
   input  logic [DW-1:0]     icb_cmd_wdata,
   input  logic [DW/8-1:0]   icb_cmd_wmask,
   output logic              icb_rsp_valid,
   input  logic              icb_rsp_ready,
   output logic [DW-1:0]     icb_rsp_rdata,
   output logic              icb_rsp_err
);
   localparam int unsigned MW   = DW / 8;
   localparam int unsigned PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int unsigned CNTW = $clog2(RSP_DEPTH + 1);

   logic [DW-1:0]     mem [2**MEM_AW];
   logic [DW-1:0]     fifo_rdata [RSP_DEPTH];
   logic              fifo_err [RSP_DEPTH];
   logic [PW-1:0]     wptr, rptr;
   logic [CNTW-1:0]   fifo_count;
   logic              fifo_space;
   logic              cmd_hs, rsp_hs, cmd_err, mem_we;
   logic [MEM_AW-1:0] cmd_idx;
   logic              enq, enq_err;
   logic [DW-1:0]     enq_rdata;

   assign cmd_idx    = icb_cmd_addr[MEM_AW+1:2];
   assign cmd_err    = (icb_cmd_addr[1:0] != 2'b00) | (icb_cmd_addr[ADDR_W-1:MEM_AW+2] != '0);
   assign fifo_space = fifo_count < CNTW'(RSP_DEPTH);
   assign cmd_hs     = icb_cmd_valid & icb_cmd_ready;
   assign rsp_hs     = icb_rsp_valid & icb_rsp_ready;
   assign mem_we     = cmd_hs & ~icb_cmd_read & ~cmd_err & ~rst;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int unsigned i = 0; i < MW; i++) begin
            if (icb_cmd_wmask[i]) mem[cmd_idx][8*i +: 8] <= icb_cmd_wdata[8*i +: 8];
         end
      end
   end

`ifdef QPU_DMEM_WAIT_EN
   localparam int unsigned WCW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC + 1) : 1;

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;
   state_t            state, state_nxt;
   logic [WCW-1:0]    cnt, cnt_nxt;
   logic [MEM_AW-1:0] l_idx;
   logic              l_read, l_err;

   assign icb_cmd_ready = fifo_space & (state == ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (cmd_hs) begin
         l_idx  <= cmd_idx;
         l_read <= icb_cmd_read;
         l_err  <= cmd_err;
      end
   end

   // The write lands at the handshake; the read is deferred so the response sees the final word.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      enq       = 1'b0;
      enq_err   = 1'b0;
      enq_rdata = '0;
      if (WAIT_CYC == 0) begin
         enq       = cmd_hs;
         enq_err   = cmd_err;
         enq_rdata = (icb_cmd_read & ~cmd_err) ? mem[cmd_idx] : '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_hs) begin
                  state_nxt = ST_WAIT;
                  cnt_nxt   = WCW'(WAIT_CYC);
               end
            end
            ST_WAIT: begin
               cnt_nxt = cnt - 1'b1;
               if (cnt == WCW'(1)) begin
                  enq       = 1'b1;
                  enq_err   = l_err;
                  enq_rdata = (l_read & ~l_err) ? mem[l_idx] : '0;
                  state_nxt = ST_IDLE;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end
`else
   assign icb_cmd_ready = fifo_space;

   always_comb begin
      enq       = cmd_hs;
      enq_err   = cmd_err;
      enq_rdata = (icb_cmd_read & ~cmd_err) ? mem[cmd_idx] : '0;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr       <= '0;
         rptr       <= '0;
         fifo_count <= '0;
      end else begin
         if (enq)    wptr <= (wptr == PW'(RSP_DEPTH - 1)) ? '0 : wptr + 1'b1;
         if (rsp_hs) rptr <= (rptr == PW'(RSP_DEPTH - 1)) ? '0 : rptr + 1'b1;
         case ({enq, rsp_hs})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         fifo_rdata[wptr] <= enq_rdata;
         fifo_err[wptr]   <= enq_err;
      end
   end

   // Outputs are forced to zero when empty so the unreset storage never leaks out.
   assign icb_rsp_valid = (fifo_count != '0);
   assign icb_rsp_rdata = icb_rsp_valid ? fifo_rdata[rptr] : '0;
   assign icb_rsp_err   = icb_rsp_valid ? fifo_err[rptr] : 1'b0;

endmodule

// File: tb/tb_qpu_dmem_icb_slave.sv
// Directed self-checking bench for qpu_dmem_icb_slave in its default build (no wait states).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_qpu_dmem_icb_slave;
   logic        clk = 1'b0;
   logic        rst;
   logic        icb_cmd_valid;
   logic        icb_cmd_ready;
   logic [15:0] icb_cmd_addr;
   logic        icb_cmd_read;
   logic [31:0] icb_cmd_wdata;
   logic [3:0]  icb_cmd_wmask;
   logic        icb_rsp_valid;
   logic        icb_rsp_ready;
   logic [31:0] icb_rsp_rdata;
   logic        icb_rsp_err;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   qpu_dmem_icb_slave #(
      .ADDR_W   (16),
      .DW       (32),
      .MEM_AW   (8),
      .RSP_DEPTH(2),
      .WAIT_CYC (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .icb_cmd_valid(icb_cmd_valid),
      .icb_cmd_ready(icb_cmd_ready),
      .icb_cmd_addr (icb_cmd_addr),
      .icb_cmd_read (icb_cmd_read),
      .icb_cmd_wdata(icb_cmd_wdata),
      .icb_cmd_wmask(icb_cmd_wmask),
      .icb_rsp_valid(icb_rsp_valid),
      .icb_rsp_ready(icb_rsp_ready),
      .icb_rsp_rdata(icb_rsp_rdata),
      .icb_rsp_err  (icb_rsp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic drive(input logic v, input logic rd, input logic [15:0] a,
                        input logic [31:0] wd, input logic [3:0] m);
      icb_cmd_valid = v;
      icb_cmd_read  = rd;
      icb_cmd_addr  = a;
      icb_cmd_wdata = wd;
      icb_cmd_wmask = m;
   endtask

   // One command with rsp_ready=1: response must appear the next cycle and then drain.
   task automatic single(input string tag, input logic rd, input logic [15:0] a,
                         input logic [31:0] wd, input logic [3:0] m,
                         input logic [31:0] exp_rdata, input logic exp_err);
      check({tag, ".ready"}, 32'(icb_cmd_ready), 32'd1);
      drive(1'b1, rd, a, wd, m);
      @(negedge clk);
      drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
      check({tag, ".valid"}, 32'(icb_rsp_valid), 32'd1);
      check({tag, ".rdata"}, icb_rsp_rdata, exp_rdata);
      check({tag, ".err"},   32'(icb_rsp_err), 32'(exp_err));
      @(negedge clk);
      check({tag, ".drained"}, 32'(icb_rsp_valid), 32'd0);
   endtask

   function automatic logic [31:0] pat(input int unsigned i);
      return (32'(i) * 32'h01010101) ^ 32'hA5000000;
   endfunction

   initial begin
      rst           = 1'b1;
      icb_rsp_ready = 1'b1;
      drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
      repeat (2) @(negedge clk);
      check("rst.valid", 32'(icb_rsp_valid), 32'd0);
      check("rst.ready", 32'(icb_cmd_ready), 32'd1);
      check("rst.rdata", icb_rsp_rdata, 32'h0);
      check("rst.err",   32'(icb_rsp_err), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Write then read the same word in back-to-back cycles.
      drive(1'b1, 1'b0, 16'h0010, 32'hDEADBEEF, 4'hF);
      @(negedge clk);
      drive(1'b1, 1'b1, 16'h0010, 32'h0, 4'h0);
      check("raw.wr_valid", 32'(icb_rsp_valid), 32'd1);
      check("raw.wr_rdata", icb_rsp_rdata, 32'h0);
      check("raw.wr_err",   32'(icb_rsp_err), 32'd0);
      @(negedge clk);
      drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
      check("raw.rd_valid", 32'(icb_rsp_valid), 32'd1);
      check("raw.rd_rdata", icb_rsp_rdata, 32'hDEADBEEF);
      check("raw.rd_err",   32'(icb_rsp_err), 32'd0);
      @(negedge clk);
      check("raw.drained", 32'(icb_rsp_valid), 32'd0);

      single("pw.wr", 1'b0, 16'h0010, 32'h11223344, 4'h5, 32'h0, 1'b0);
      single("pw.rd", 1'b1, 16'h0010, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);
      single("m0.wr", 1'b0, 16'h0010, 32'h99999999, 4'h0, 32'h0, 1'b0);
      single("m0.rd", 1'b1, 16'h0010, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);

      // Error accesses alias words 0 and 4 if decoded; neither may change.
      single("w0.wr",   1'b0, 16'h0000, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
      single("mis.wr",  1'b0, 16'h0011, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
      single("mis.rd",  1'b1, 16'h0011, 32'h0, 4'h0, 32'h0, 1'b1);
      single("oor.wr",  1'b0, 16'h0400, 32'h12345678, 4'hF, 32'h0, 1'b1);
      single("oor.rd",  1'b1, 16'h0400, 32'h0, 4'h0, 32'h0, 1'b1);
      single("hi.err",  1'b1, 16'h8000, 32'h0, 4'h0, 32'h0, 1'b1);
      single("w4.keep", 1'b1, 16'h0010, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);
      single("w0.keep", 1'b1, 16'h0000, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
      single("top.wr",  1'b0, 16'h03FC, 32'h0BADC0DE, 4'hF, 32'h0, 1'b0);
      single("top.rd",  1'b1, 16'h03FC, 32'h0, 4'h0, 32'h0BADC0DE, 1'b0);

      // Backpressure: two reads fill the FIFO, third waits until a slot frees.
      icb_rsp_ready = 1'b0;
      drive(1'b1, 1'b1, 16'h0010, 32'h0, 4'h0);
      @(negedge clk);
      check("bp.ready1", 32'(icb_cmd_ready), 32'd1);
      drive(1'b1, 1'b1, 16'h0000, 32'h0, 4'h0);
      @(negedge clk);
      drive(1'b1, 1'b1, 16'h03FC, 32'h0, 4'h0);
      check("bp.full_ready", 32'(icb_cmd_ready), 32'd0);
      check("bp.head_a", icb_rsp_rdata, 32'hDE22BE44);
      @(negedge clk);
      check("bp.hold_ready", 32'(icb_cmd_ready), 32'd0);
      check("bp.hold_head", icb_rsp_rdata, 32'hDE22BE44);
      icb_rsp_ready = 1'b1;
      #1;
      check("bp.no_passthru", 32'(icb_cmd_ready), 32'd0);
      @(negedge clk);
      check("bp.head_b", icb_rsp_rdata, 32'hCAFEF00D);
      check("bp.ready_again", 32'(icb_cmd_ready), 32'd1);
      @(negedge clk);
      drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
      check("bp.head_c_valid", 32'(icb_rsp_valid), 32'd1);
      check("bp.head_c", icb_rsp_rdata, 32'h0BADC0DE);
      @(negedge clk);
      check("bp.drained", 32'(icb_rsp_valid), 32'd0);

      // Streaming: fill words 0..15, then 16 back-to-back reads.
      for (int unsigned i = 0; i < 16; i++) begin
         drive(1'b1, 1'b0, 16'(4 * i), pat(i), 4'hF);
         @(negedge clk);
      end
      drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
      @(negedge clk);
      for (int unsigned c = 0; c <= 16; c++) begin
         if (c > 0) begin
            check($sformatf("st.valid%0d", c - 1), 32'(icb_rsp_valid), 32'd1);
            check($sformatf("st.rdata%0d", c - 1), icb_rsp_rdata, pat(c - 1));
         end
         check($sformatf("st.ready%0d", c), 32'(icb_cmd_ready), 32'd1);
         if (c < 16) drive(1'b1, 1'b1, 16'(4 * c), 32'h0, 4'h0);
         else        drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
         @(negedge clk);
      end
      check("st.drained", 32'(icb_rsp_valid), 32'd0);

      // Reset with two queued responses drops both.
      icb_rsp_ready = 1'b0;
      drive(1'b1, 1'b1, 16'h0004, 32'h0, 4'h0);
      @(negedge clk);
      drive(1'b1, 1'b1, 16'h0008, 32'h0, 4'h0);
      @(negedge clk);
      drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
      check("rq.queued_valid", 32'(icb_rsp_valid), 32'd1);
      check("rq.queued_ready", 32'(icb_cmd_ready), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rq.valid", 32'(icb_rsp_valid), 32'd0);
      check("rq.ready", 32'(icb_cmd_ready), 32'd1);
      icb_rsp_ready = 1'b1;
      @(negedge clk);
      check("rq.still_empty", 32'(icb_rsp_valid), 32'd0);
      single("rq.after", 1'b1, 16'h0008, 32'h0, 4'h0, pat(2), 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
